// File: rtl/data_memory_port.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_port
// Brief    : Load/store port between execute stage and a word-wide req/ack
//            data bus: byte enables, lane shifting, load extension, stall.
//            Optional misaligned support: DATA_MEMORY_PORT_MISALIGNED_EN.
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_port #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_mask,      // 00 byte, 01 half, 1x word
    input  logic              req_sign_ext,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);
    localparam int c_aw    = ADDR_W - 2;
    localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);
`ifdef DATA_MEMORY_PORT_MISALIGNED_EN
    localparam int c_lanes = 8;
`else
    localparam int c_lanes = 4;
`endif
    localparam int c_dw = c_lanes * 8;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_beat0 = 2'd1;
`ifdef DATA_MEMORY_PORT_MISALIGNED_EN
    localparam logic [1:0] c_st_beat1 = 2'd2;
`endif
    localparam logic [1:0] c_st_done  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               w_timeout;

    logic               r_we;
    logic [1:0]         r_mask;
    logic               r_sext;
    logic [1:0]         r_off;
    logic [c_aw-1:0]    r_waddr;
    logic [c_lanes-1:0] r_be;
    logic [c_dw-1:0]    r_wd;
    logic               r_err;
    logic [c_cnt_w-1:0] r_cnt;
    logic [31:0]        r_rd_lo;
`ifdef DATA_MEMORY_PORT_MISALIGNED_EN
    logic [31:0]        r_rd_hi;
    logic               r_cross;
    logic               w_cross;
`else
    logic               w_misal;
`endif

    logic [1:0]         w_off;
    logic [2:0]         w_size;
    logic [c_lanes-1:0] w_be;
    logic [c_dw-1:0]    w_wd;
    logic [31:0]        w_rd_sh;
    logic [31:0]        w_load;

    assign w_off = req_addr[1:0];

    // Request decode: size, lane-shifted enables and data
    always_comb begin
        w_size = 3'd4;
        w_be   = c_lanes'(4'b1111);
        if (req_mask == 2'b00) begin
            w_size = 3'd1;
            w_be   = c_lanes'(4'b0001);
        end else if (req_mask == 2'b01) begin
            w_size = 3'd2;
            w_be   = c_lanes'(4'b0011);
        end
        w_be = w_be << w_off;
        w_wd = c_dw'(req_wdata);
        w_wd = w_wd << {w_off, 3'b000};
`ifdef DATA_MEMORY_PORT_MISALIGNED_EN
        w_cross = ({1'b0, w_off} + w_size) > 3'd4;
`else
        w_misal = ((w_size == 3'd2) && w_off[0]) ||
                  ((w_size == 3'd4) && (w_off != 2'b00));
`endif
    end

    // Load realignment and extension
    always_comb begin
`ifdef DATA_MEMORY_PORT_MISALIGNED_EN
        w_rd_sh = 32'({r_rd_hi, r_rd_lo} >> {r_off, 3'b000});
`else
        w_rd_sh = r_rd_lo >> {r_off, 3'b000};
`endif
        if (r_mask == 2'b00) begin
            w_load = {{24{r_sext & w_rd_sh[7]}}, w_rd_sh[7:0]};
        end else if (r_mask == 2'b01) begin
            w_load = {{16{r_sext & w_rd_sh[15]}}, w_rd_sh[15:0]};
        end else begin
            w_load = w_rd_sh;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        stall       = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_be      = '0;
        mem_wdata   = '0;
        rsp_valid   = 1'b0;
        rsp_err     = 1'b0;
        rsp_rdata   = '0;
        case (r_state)
            c_st_idle: begin
                if (req_valid) begin
                    stall = 1'b1;
`ifdef DATA_MEMORY_PORT_MISALIGNED_EN
                    w_state_nxt = c_st_beat0;
`else
                    w_state_nxt = w_misal ? c_st_done : c_st_beat0;
`endif
                end
            end
            c_st_beat0: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = r_we;
                mem_addr  = r_waddr;
                mem_be    = r_be[3:0];
                mem_wdata = r_wd[31:0];
                if (mem_ack) begin
`ifdef DATA_MEMORY_PORT_MISALIGNED_EN
                    w_state_nxt = r_cross ? c_st_beat1 : c_st_done;
`else
                    w_state_nxt = c_st_done;
`endif
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = c_st_done;
                    w_timeout   = 1'b1;
                end
            end
`ifdef DATA_MEMORY_PORT_MISALIGNED_EN
            c_st_beat1: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = r_we;
                mem_addr  = r_waddr + c_aw'(1);
                mem_be    = r_be[7:4];
                mem_wdata = r_wd[63:32];
                if (mem_ack) begin
                    w_state_nxt = c_st_done;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = c_st_done;
                    w_timeout   = 1'b1;
                end
            end
`endif
            c_st_done: begin
                rsp_valid   = 1'b1;
                rsp_err     = r_err;
                rsp_rdata   = (r_err || r_we) ? 32'h0 : w_load;
                w_state_nxt = c_st_idle;
            end
            default: w_state_nxt = c_st_idle;
        endcase
        // Keep the pipeline free while reset is asserted, whatever req_valid does
        if (!rst_n) stall = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_st_idle;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_mask  <= 2'b00;
            r_sext  <= 1'b0;
            r_off   <= 2'b00;
            r_waddr <= '0;
            r_be    <= '0;
            r_wd    <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_rd_lo <= '0;
`ifdef DATA_MEMORY_PORT_MISALIGNED_EN
            r_rd_hi <= '0;
            r_cross <= 1'b0;
`endif
        end else begin
            if ((r_state == c_st_idle) && req_valid) begin
                r_we    <= req_we;
                r_mask  <= req_mask;
                r_sext  <= req_sign_ext;
                r_off   <= w_off;
                r_waddr <= req_addr[ADDR_W-1:2];
                r_be    <= w_be;
                r_wd    <= w_wd;
                r_cnt   <= '0;
`ifdef DATA_MEMORY_PORT_MISALIGNED_EN
                r_err   <= 1'b0;
                r_cross <= w_cross;
`else
                r_err   <= w_misal;
`endif
            end
            if (mem_req) r_cnt <= mem_ack ? '0 : r_cnt + c_cnt_w'(1);
            if (w_timeout) r_err <= 1'b1;
            if ((r_state == c_st_beat0) && mem_ack) r_rd_lo <= mem_rdata;
`ifdef DATA_MEMORY_PORT_MISALIGNED_EN
            if ((r_state == c_st_beat1) && mem_ack) r_rd_hi <= mem_rdata;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_memory_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_port
// Brief    : Self-checking bench for data_memory_port against a byte-level
//            reference memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_port;
    localparam int ADDR_W         = 32;
    localparam int TIMEOUT_CYCLES = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_mask = 2'b00;
    logic        req_sign_ext = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        stall, rsp_valid, rsp_err, mem_req, mem_we;
    logic [31:0] rsp_rdata, mem_wdata;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    always #5 clk = ~clk;

    data_memory_port #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
        .req_mask(req_mask), .req_sign_ext(req_sign_ext), .req_addr(req_addr),
        .req_wdata(req_wdata), .stall(stall), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] wmem [int unsigned];

    // Observations of one access
    int          o_stall, o_req_cyc, ob_n;
    logic        o_got, o_err, o_first_stall, o_req_at_rsp, o_stall_at_rsp;
    logic [31:0] o_rdata;
    logic [29:0] ob_addr [4];
    logic [3:0]  ob_be [4];
    logic [31:0] ob_wd [4];
    logic        ob_we [4];

    function automatic logic [31:0] word_at(input logic [29:0] a);
        int unsigned k;
        k = 32'(a);
        if (wmem.exists(k)) return wmem[k];
        return ({2'b00, a} * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [7:0] byte_at(input logic [31:0] b);
        logic [31:0] w;
        w = word_at(b[31:2]);
        return w[8*b[1:0] +: 8];
    endfunction

    function automatic int size_of(input logic [1:0] m);
        return (m == 2'b00) ? 1 : (m == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] addr, input logic [1:0] m, input logic sx);
        int sz;
        logic [31:0] v, b;
        sz = size_of(m);
        v  = 32'h0;
        for (int i = 0; i < sz; i++) begin
            b = addr + 32'(i);
            v = v | ({24'h0, byte_at(b)} << (8 * i));
        end
        if (sz < 4 && sx && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
        return v;
    endfunction

    function automatic logic rejected(input logic [31:0] addr, input logic [1:0] m);
`ifdef DATA_MEMORY_PORT_MISALIGNED_EN
        return 1'b0;
`else
        return (size_of(m) == 2 && addr[0]) || (size_of(m) == 4 && addr[1:0] != 2'b00);
`endif
    endfunction

    // Presents one request and acts as the bus slave; ack after ack_wait idle beat cycles
    task automatic run_access(input logic we, input logic [1:0] m, input logic sx,
                              input logic [31:0] addr, input logic [31:0] wd, input int ack_wait);
        int bw;
        req_valid = 1'b1; req_we = we; req_mask = m; req_sign_ext = sx;
        req_addr = addr; req_wdata = wd; mem_ack = 1'b0;
        ob_n = 0; o_stall = 0; o_req_cyc = 0; o_got = 1'b0; bw = 0;
        o_err = 1'b0; o_rdata = 32'h0; o_first_stall = 1'b0;
        o_req_at_rsp = 1'b0; o_stall_at_rsp = 1'b0;
        for (int cyc = 0; cyc < 64 && !o_got; cyc++) begin
            #1;
            if (cyc == 0) o_first_stall = stall;
            if (rsp_valid) begin
                o_got = 1'b1; o_rdata = rsp_rdata; o_err = rsp_err;
                o_req_at_rsp = mem_req; o_stall_at_rsp = stall;
                mem_ack = 1'b1;  // stray ack outside a beat
            end else begin
                if (stall) o_stall++;
                mem_ack = 1'b0;
                if (mem_req) begin
                    o_req_cyc++;
                    if (bw == ack_wait) begin
                        mem_ack = 1'b1;
                        mem_rdata = word_at(mem_addr);
                        if (ob_n < 4) begin
                            ob_addr[ob_n] = mem_addr; ob_be[ob_n] = mem_be;
                            ob_wd[ob_n] = mem_wdata; ob_we[ob_n] = mem_we;
                        end
                        ob_n++;
                        bw = 0;
                    end else begin
                        mem_rdata = $urandom;
                        bw++;
                    end
                end
            end
            @(negedge clk);
            mem_ack = 1'b0;
        end
        req_valid = 1'b0;
        if (!o_got) begin
            checks++; errors++;
            $display("FAIL rsp_timeout: no rsp_valid within 64 cycles (addr %h)", addr);
        end
    endtask

    task automatic test_reset();
        req_valid = 1'b1; mem_ack = 1'b1;
        #12;
        checks++;
        if ({stall, rsp_valid, rsp_err, mem_req, mem_we, mem_be, rsp_rdata, mem_addr, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: stall=%b rsp_valid=%b rsp_err=%b mem_req=%b mem_we=%b be=%b rdata=%h addr=%h wdata=%h, expected all zero",
                     stall, rsp_valid, rsp_err, mem_req, mem_we, mem_be, rsp_rdata, mem_addr, mem_wdata);
        end
        req_valid = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_store_byte();
        run_access(1'b1, 2'b00, 1'b0, 32'h0000_0103, 32'h0000_00A5, 0);
        checks++;
        if (ob_n !== 1 || ob_addr[0] !== 30'h40 || ob_be[0] !== 4'b1000 || ob_wd[0] !== 32'hA500_0000 || ob_we[0] !== 1'b1) begin
            errors++;
            $display("FAIL store_byte_bus: beats=%0d addr=%h be=%b wdata=%h we=%b, expected 1 40 1000 a5000000 1",
                     ob_n, ob_addr[0], ob_be[0], ob_wd[0], ob_we[0]);
        end
        checks++;
        if (o_stall !== 2 || o_err !== 1'b0 || o_rdata !== 32'h0) begin
            errors++;
            $display("FAIL store_byte_rsp: stall_cycles=%0d err=%b rdata=%h, expected 2 0 0", o_stall, o_err, o_rdata);
        end
    endtask

    task automatic test_loads();
        wmem[32'h80] = 32'h8001_1234;
        run_access(1'b0, 2'b01, 1'b1, 32'h0000_0202, 32'h0, 0);
        checks++;
        if (o_rdata !== 32'hFFFF_8001 || o_err !== 1'b0 || ob_be[0] !== 4'b1100) begin
            errors++;
            $display("FAIL load_half_signed: rdata=%h err=%b be=%b, expected ffff8001 0 1100", o_rdata, o_err, ob_be[0]);
        end
        run_access(1'b0, 2'b00, 1'b0, 32'h0000_0200, 32'h0, 1);
        checks++;
        if (o_rdata !== 32'h0000_0034 || o_err !== 1'b0 || ob_addr[0] !== 30'h80) begin
            errors++;
            $display("FAIL load_byte_unsigned: rdata=%h err=%b addr=%h, expected 00000034 0 80", o_rdata, o_err, ob_addr[0]);
        end
    endtask

    task automatic test_crossing();
        wmem[32'h1] = 32'h4433_2211;
        wmem[32'h2] = 32'h8877_6655;
        run_access(1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0, 0);
`ifdef DATA_MEMORY_PORT_MISALIGNED_EN
        checks++;
        if (ob_n !== 2 || ob_be[0] !== 4'b1100 || ob_be[1] !== 4'b0011 || ob_addr[0] !== 30'h1 || ob_addr[1] !== 30'h2) begin
            errors++;
            $display("FAIL cross_beats: n=%0d be0=%b be1=%b a0=%h a1=%h, expected 2 1100 0011 1 2",
                     ob_n, ob_be[0], ob_be[1], ob_addr[0], ob_addr[1]);
        end
        checks++;
        if (o_rdata !== 32'h6655_4433 || o_err !== 1'b0) begin
            errors++;
            $display("FAIL cross_rdata: rdata=%h err=%b, expected 66554433 0", o_rdata, o_err);
        end
`else
        checks++;
        if (o_err !== 1'b1 || o_rdata !== 32'h0 || o_req_cyc !== 0 || o_stall !== 1) begin
            errors++;
            $display("FAIL misaligned_reject: err=%b rdata=%h req_cycles=%0d stall_cycles=%0d, expected 1 0 0 1",
                     o_err, o_rdata, o_req_cyc, o_stall);
        end
`endif
    endtask

    task automatic test_timeout();
        run_access(1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0, TIMEOUT_CYCLES);
        checks++;
        if (o_err !== 1'b1 || o_rdata !== 32'h0 || o_req_cyc !== TIMEOUT_CYCLES || o_req_at_rsp !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err: err=%b rdata=%h req_cycles=%0d req_at_rsp=%b, expected 1 0 %0d 0",
                     o_err, o_rdata, o_req_cyc, o_req_at_rsp, TIMEOUT_CYCLES);
        end
        run_access(1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0, TIMEOUT_CYCLES - 1);
        checks++;
        if (o_err !== 1'b0 || o_rdata !== word_at(30'hC0) || o_req_cyc !== TIMEOUT_CYCLES) begin
            errors++;
            $display("FAIL timeout_last_ack: err=%b rdata=%h req_cycles=%0d, expected 0 %h %0d",
                     o_err, o_rdata, o_req_cyc, word_at(30'hC0), TIMEOUT_CYCLES);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        req_valid = 1'b1; req_we = 1'b0; req_mask = 2'b10; req_sign_ext = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h0; mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre: mem_req=%b, expected 1", mem_req);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_drop: mem_req=%b stall=%b, expected 0 0", mem_req, stall);
        end
        @(negedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b1;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (rsp_valid || mem_req) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reset_mid_no_rsp: %0d cycles with rsp_valid/mem_req after release, expected 0", bad);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int bad;
        run_access(1'b0, 2'b01, 1'b0, 32'h0000_0202, 32'h0, 2);
        checks++;
        if (o_rdata !== 32'h0000_8001 || o_err !== 1'b0 || o_stall !== 4) begin
            errors++;
            $display("FAIL b2b_load: rdata=%h err=%b stall_cycles=%0d, expected 00008001 0 4", o_rdata, o_err, o_stall);
        end
        run_access(1'b1, 2'b00, 1'b0, 32'h0000_0201, 32'h0000_005C, 2);
        checks++;
        if (o_first_stall !== 1'b1 || o_stall !== 4 || ob_n !== 1 || ob_be[0] !== 4'b0010 || ob_wd[0] !== 32'h0000_5C00) begin
            errors++;
            $display("FAIL b2b_store: first_stall=%b stall_cycles=%0d beats=%0d be=%b wdata=%h, expected 1 4 1 0010 00005c00",
                     o_first_stall, o_stall, ob_n, ob_be[0], ob_wd[0]);
        end
        bad = 0;
        repeat (3) begin
            #1;
            if (rsp_valid) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL b2b_extra_rsp: %0d extra rsp_valid pulses, expected 0", bad);
        end
    endtask

    task automatic test_random(input int n);
        logic        we, sx, rej;
        logic [1:0]  m;
        logic [31:0] addr, wd, erd;
        logic [29:0] ea;
        logic [3:0]  ebe [2];
        logic [31:0] ewd [2];
        int aw, sz, nb, pos, k, lane, estall;
        for (int t = 0; t < n; t++) begin
            we = 1'($urandom); sx = 1'($urandom); m = 2'($urandom_range(0, 2));
            addr = $urandom; wd = $urandom; aw = $urandom_range(0, 3);
            if (t % 8 == 0) addr[31:4] = '1;
            sz = size_of(m);
            ebe[0] = 4'h0; ebe[1] = 4'h0; ewd[0] = 32'h0; ewd[1] = 32'h0; nb = 1;
            for (int i = 0; i < 4; i++) begin
                pos = int'(addr[1:0]) + i;
                k = pos / 4; lane = pos % 4;
                ewd[k][8*lane +: 8] = wd[8*i +: 8];
                if (i < sz) begin
                    ebe[k][lane] = 1'b1;
                    if (k + 1 > nb) nb = k + 1;
                end
            end
            rej = rejected(addr, m);
            erd = (rej || we) ? 32'h0 : exp_load(addr, m, sx);
            estall = rej ? 1 : 1 + nb * (aw + 1);
            run_access(we, m, sx, addr, wd, aw);
            checks++;
            if (o_err !== rej || o_rdata !== erd) begin
                errors++;
                $display("FAIL rnd_rsp[%0d]: err=%b rdata=%h, expected %b %h (we=%b mask=%b addr=%h)",
                         t, o_err, o_rdata, rej, erd, we, m, addr);
            end
            checks++;
            if (o_stall !== estall || o_stall_at_rsp !== 1'b0 || o_req_at_rsp !== 1'b0) begin
                errors++;
                $display("FAIL rnd_stall[%0d]: stall_cycles=%0d stall_at_rsp=%b req_at_rsp=%b, expected %0d 0 0",
                         t, o_stall, o_stall_at_rsp, o_req_at_rsp, estall);
            end
            checks++;
            if (ob_n !== (rej ? 0 : nb)) begin
                errors++;
                $display("FAIL rnd_beats[%0d]: beats=%0d, expected %0d", t, ob_n, rej ? 0 : nb);
            end else if (!rej) begin
                for (int b = 0; b < nb; b++) begin
                    ea = addr[31:2] + 30'(b);
                    checks++;
                    if (ob_addr[b] !== ea || ob_be[b] !== ebe[b] || ob_wd[b] !== ewd[b] || ob_we[b] !== we) begin
                        errors++;
                        $display("FAIL rnd_beat[%0d.%0d]: addr=%h be=%b wdata=%h we=%b, expected %h %b %h %b",
                                 t, b, ob_addr[b], ob_be[b], ob_wd[b], ob_we[b], ea, ebe[b], ewd[b], we);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_loads();
        test_crossing();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random(200);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
